// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the control-transfer sequencer.
// Contents: opcode/funct constants, datapath select encodings, and the
// sequencer state enum. There are no ports because this is a package.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [4:0] LINK_REG = 5'd31;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_BR_OFF  = 2'b11;

  localparam logic [2:0] ALU_ADD      = 3'b000;
  localparam logic [2:0] ALU_SUB      = 3'b001;
  localparam logic [2:0] ALU_PASS_A   = 3'b111;

  localparam logic [1:0] REGDST_LINK  = 2'b10;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TGT  = 3'd1,
    ST_CMP  = 3'd2,
    ST_LINK = 3'd3,
    ST_JMP  = 3'd4,
    ST_JR   = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

endpackage

// File: rtl/bj_decode.sv
// Instruction classifier for the control-transfer sequencer.
// Maps {opcode, funct} to the first state of the matching sequence.
// Ports:
//   opcode     in  6  instr[31:26]
//   funct      in  6  instr[5:0]
//   next_state out    first sequence state (ST_ERR for unsupported encodings)
module bj_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next_state
);

  always_comb begin
    next_state = ST_ERR;
    case (opcode)
      OP_BEQ, OP_BNE: next_state = ST_TGT;
      OP_J:           next_state = ST_JMP;
      OP_JAL:         next_state = ST_LINK;
      OP_RTYPE:       next_state = (funct == FN_JR) ? ST_JR : ST_ERR;
      default:        next_state = ST_ERR;
    endcase
  end

endmodule

// File: rtl/branch_jump_seq.sv
// Multicycle sequencer for BEQ, BNE, J, JAL and JR. It is handed a decoded
// instruction by the main FSM and drives the PC-write controller and the
// datapath selects.
//
// state | meaning
// IDLE  | waiting for start, all outputs 0
// TGT   | branch target = PC + (signext(imm) << 2) into ALUOut
// CMP   | A - B compare; the downstream controller decides taken
// LINK  | write PC into LINK_REG (JAL)
// JMP   | PC <= jump target
// JR    | PC <= register A
// ERR   | unsupported opcode/funct, pulse illegal
//
// Ports:
//   clk, reset_n (synchronous, active-low)
//   start, opcode, funct                      request from the main FSM
//   busy, done, illegal                       handshake/status
//   pc_write, is_beq, is_bne, pc_source       to the PC-write controller
//   alu_src_a, alu_src_b, alu_op, aluout_write ALU controls
//   reg_write, reg_dst, mem_to_reg            link writeback
module branch_jump_seq
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       pc_write,
  output logic       is_beq,
  output logic       is_bne,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       aluout_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg
);

  state_t     state_q;
  state_t     state_d;
  state_t     decoded;
  logic [5:0] opcode_q;

  bj_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (decoded)
  );

  // Only the opcode is kept: funct matters solely for the JR/illegal split,
  // which is settled by the decoder at the start edge. The opcode is still
  // needed in CMP to choose between is_beq and is_bne.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        opcode_q <= opcode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = decoded;
      ST_TGT:  state_d = ST_CMP;
      ST_LINK: state_d = ST_JMP;
      ST_CMP, ST_JMP, ST_JR, ST_ERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode: opcode_q is a register, so outputs depend on flops only.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    illegal      = 1'b0;
    pc_write     = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    pc_source    = PCSRC_ALU;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_REG;
    alu_op       = ALU_ADD;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    case (state_q)
      ST_TGT: begin
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_BR_OFF;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
      end
      ST_CMP: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        is_beq    = (opcode_q == OP_BEQ);
        is_bne    = (opcode_q == OP_BNE);
        done      = 1'b1;
      end
      ST_LINK: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_LINK;
        mem_to_reg = MEMTOREG_PC;
      end
      ST_JMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        done      = 1'b1;
      end
      ST_JR: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALU_PASS_A;
        pc_source = PCSRC_ALU;
        pc_write  = 1'b1;
        done      = 1'b1;
      end
      ST_ERR: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_jump_seq.sv
// Self-checking bench for branch_jump_seq: queue-based reference model of the
// per-cycle output vectors, a per-cycle compare process, directed literal
// checks, and randomized traffic with occasional resets.
module tb_branch_jump_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       busy, done, illegal, pc_write, is_beq, is_bne;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       aluout_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg;

  branch_jump_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .funct(funct),
    .busy(busy), .done(done), .illegal(illegal), .pc_write(pc_write),
    .is_beq(is_beq), .is_bne(is_bne), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .aluout_write(aluout_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, done, illegal, pc_write, is_beq, is_bne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
  } outs_t;

  int n_checks = 0;
  int n_fail   = 0;
  outs_t exp_q[$];

  function automatic outs_t actual();
    outs_t a;
    a = '{busy, done, illegal, pc_write, is_beq, is_bne, pc_source, alu_src_a,
          alu_src_b, alu_op, aluout_write, reg_write, reg_dst, mem_to_reg};
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected cycle-by-cycle outputs of one instruction, straight from the
  // behaviour rules. Each entry is one clock cycle after the start edge.
  task automatic push_seq(input logic [5:0] op, input logic [5:0] fn);
    outs_t s;
    if (op == 6'h04 || op == 6'h05) begin
      s = '0; s.busy = 1; s.alu_src_b = 2'b11; s.aluout_write = 1;
      exp_q.push_back(s);
      s = '0; s.busy = 1; s.done = 1; s.alu_src_a = 1; s.alu_op = 3'b001;
      s.pc_source = 2'b01; s.is_beq = (op == 6'h04); s.is_bne = (op == 6'h05);
      exp_q.push_back(s);
    end else if (op == 6'h03) begin
      s = '0; s.busy = 1; s.reg_write = 1; s.reg_dst = 2'b10; s.mem_to_reg = 2'b10;
      exp_q.push_back(s);
      s = '0; s.busy = 1; s.done = 1; s.pc_write = 1; s.pc_source = 2'b10;
      exp_q.push_back(s);
    end else if (op == 6'h02) begin
      s = '0; s.busy = 1; s.done = 1; s.pc_write = 1; s.pc_source = 2'b10;
      exp_q.push_back(s);
    end else if (op == 6'h00 && fn == 6'h08) begin
      s = '0; s.busy = 1; s.done = 1; s.pc_write = 1; s.alu_src_a = 1;
      s.alu_op = 3'b111; s.pc_source = 2'b00;
      exp_q.push_back(s);
    end else begin
      s = '0; s.busy = 1; s.done = 1; s.illegal = 1;
      exp_q.push_back(s);
    end
  endtask

  // Reference model: a pending-cycle queue. The block is idle exactly when the
  // queue is empty before the edge, and only then may a start be taken.
  always @(posedge clk) begin
    if (!reset_n) exp_q.delete();
    else if (exp_q.size() != 0) void'(exp_q.pop_front());
    else if (start) push_seq(opcode, funct);
  end

  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    a = actual();
    check("cycle_outputs", 32'(a), 32'(e));
    check("strobe_excl",
          32'((32'(is_beq) + 32'(is_bne) + 32'(pc_write) <= 1) && !(pc_write && reg_write)),
          32'd1);
  end

  task automatic issue(input logic [5:0] op, input logic [5:0] fn);
    @(posedge clk); #2;
    start = 1; opcode = op; funct = fn;
    @(posedge clk); #2;
    start = 0; opcode = 6'($urandom); funct = 6'($urandom);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return 6'h02;
      2: return 6'h03;
      3: return 6'h04;
      4: return 6'h05;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset_n = 0; start = 0; opcode = 0; funct = 0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    check("reset_all_zero", 32'(actual()), 32'd0);

    // BEQ
    issue(6'h04, 6'h00);
    @(negedge clk);
    check("beq_tgt_aluout_write", 32'(aluout_write), 32'd1);
    check("beq_tgt_src_b", 32'(alu_src_b), 32'd3);
    @(negedge clk);
    check("beq_cmp_is_beq", 32'(is_beq), 32'd1);
    check("beq_cmp_pc_source", 32'(pc_source), 32'd1);
    check("beq_cmp_done", 32'(done), 32'd1);
    check("beq_cmp_pc_write", 32'(pc_write), 32'd0);
    @(negedge clk);
    check("beq_after_idle", 32'(actual()), 32'd0);

    // JAL
    issue(6'h03, 6'h15);
    @(negedge clk);
    check("jal_link", 32'({reg_write, reg_dst, mem_to_reg}), 32'b1_10_10);
    @(negedge clk);
    check("jal_jmp", 32'({pc_write, pc_source, done}), 32'b1_10_1);

    // JR and illegal R-type
    issue(6'h00, 6'h08);
    @(negedge clk);
    check("jr_outputs", 32'({pc_write, pc_source, alu_op, done}), 32'b1_00_111_1);
    issue(6'h00, 6'h20);
    @(negedge clk);
    check("illegal_outputs", 32'({illegal, done, pc_write}), 32'b1_1_0);

    // start held high through BNE, opcode changed to J after the start edge
    @(posedge clk); #2;
    start = 1; opcode = 6'h05; funct = 6'h00;
    @(posedge clk); #2;
    opcode = 6'h02;
    @(negedge clk);
    check("held_bne_tgt", 32'({busy, aluout_write, is_bne}), 32'b1_1_0);
    @(negedge clk);
    check("held_bne_cmp", 32'({is_bne, is_beq, done}), 32'b1_0_1);
    @(negedge clk);
    check("held_idle_gap", 32'(busy), 32'd0);
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    check("held_second_seq_j", 32'({pc_write, pc_source, done}), 32'b1_10_1);

    // reset during the TGT cycle of a BEQ
    issue(6'h04, 6'h00);
    reset_n = 0;
    @(posedge clk); #2;
    reset_n = 1;
    @(negedge clk);
    check("reset_mid_all_zero", 32'(actual()), 32'd0);
    @(negedge clk);
    check("reset_mid_no_beq", 32'({is_beq, done, busy}), 32'd0);

    // randomized traffic
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #2;
      start   = ($urandom_range(0, 2) == 0);
      opcode  = pick_op();
      funct   = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      reset_n = ($urandom_range(0, 99) != 0);
    end
    @(posedge clk); #2;
    reset_n = 1; start = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
